// File: rtl/servant_irq_ctrl_pkg.sv
// servant_irq_ctrl_pkg: shared state encoding and id-width helper for the interrupt controller
package servant_irq_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_SERVICE = 2'd2} state_e;
  function automatic int idw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/servant_irq_sync.sv
// servant_irq_sync: one channel synchroniser, rising-edge detect and pending latch
module servant_irq_sync #(
  parameter bit EDGE     = 1'b0,
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);
  logic [SYNC_STG-1:0] sync_q;
  logic s_lvl, s_q, pend_q;
  assign s_lvl  = sync_q[SYNC_STG-1];
  assign pend_o = EDGE ? pend_q : s_lvl;
  // a new edge in the same cycle as a take keeps the channel pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], irq_i};
      s_q    <= s_lvl;
      pend_q <= (s_lvl & ~s_q) | (pend_q & ~clr_i);
    end
  end
endmodule

// File: rtl/servant_irq_ctrl.sv
// servant_irq_ctrl: N-channel interrupt front end with fixed-priority grant, cpu handshake,
// taken-channel id and request-to-take latency reporting
module servant_irq_ctrl
  import servant_irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter int                 SYNC_STG  = 2,
  parameter int                 LAT_W     = 16
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic [NUM_IRQ-1:0]       i_irq,
  input  logic [NUM_IRQ-1:0]       i_mask,
  input  logic                     i_new_irq,
  input  logic                     i_mret,
  output logic                     o_ext_irq,
  output logic [idw(NUM_IRQ)-1:0]  o_irq_id,
  output logic [NUM_IRQ-1:0]       o_pending,
  output logic [LAT_W-1:0]         o_latency,
  output logic                     o_latency_vld,
  output logic                     o_spurious
);
  localparam int IDW = idw(NUM_IRQ);
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  logic [NUM_IRQ-1:0] pend, mask_q;
  logic [IDW-1:0]     win;
  logic [LAT_W-1:0]   cnt_q;
  state_e             state_q;
  logic               take;
  assign take      = state_q == S_REQ && i_new_irq;
  assign o_pending = pend & mask_q;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    servant_irq_sync #(.EDGE(EDGE_MASK[i]), .SYNC_STG(SYNC_STG)) u_sync (
      .clk_i  (wb_clk),
      .rst_ni (wb_rst_n),
      .irq_i  (i_irq[i]),
      .clr_i  (take && o_irq_id == IDW'(i)),
      .pend_o (pend[i])
    );
  end
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) win = o_pending[i] ? IDW'(i) : win;
  end
  // mask is registered so o_pending depends on flops only
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      cnt_q         <= '0;
      o_ext_irq     <= 1'b0;
      o_irq_id      <= '0;
      o_latency     <= '0;
      o_latency_vld <= 1'b0;
      o_spurious    <= 1'b0;
    end else begin
      mask_q        <= i_mask;
      o_latency_vld <= 1'b0;
      o_spurious    <= (i_new_irq && state_q != S_REQ) || (i_mret && state_q != S_SERVICE);
      case (state_q)
        S_IDLE: if (|o_pending) begin
          state_q   <= S_REQ;
          o_irq_id  <= win;
          o_ext_irq <= 1'b1;
          cnt_q     <= '0;
        end
        S_REQ: if (i_new_irq) begin
          state_q       <= S_SERVICE;
          o_ext_irq     <= 1'b0;
          o_latency     <= cnt_q == LAT_MAX ? LAT_MAX : cnt_q + 1'b1;
          o_latency_vld <= 1'b1;
        end else if (!o_pending[o_irq_id]) begin
          state_q   <= S_IDLE;
          o_ext_irq <= 1'b0;
        end else begin
          cnt_q <= cnt_q == LAT_MAX ? LAT_MAX : cnt_q + 1'b1;
        end
        S_SERVICE: if (i_mret) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_servant_irq_ctrl.sv
// tb_servant_irq_ctrl: directed scenarios plus randomized priority/latency checks against a
// behavioural model of the interrupt controller
module tb_servant_irq_ctrl;
  localparam int LAT_W = 4;
  localparam int LMAX  = 15;
  logic       wb_clk = 1'b0, wb_rst_n = 1'b0;
  logic [3:0] i_irq = '0, i_mask = 4'hF;
  logic       i_new_irq = 1'b0, i_mret = 1'b0;
  logic       o_ext_irq, o_latency_vld, o_spurious;
  logic [1:0] o_irq_id;
  logic [3:0] o_pending;
  logic [LAT_W-1:0] o_latency;
  int n_chk = 0, n_fail = 0;

  servant_irq_ctrl #(.NUM_IRQ(4), .EDGE_MASK(4'b0100), .SYNC_STG(2), .LAT_W(LAT_W)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_irq(i_irq), .i_mask(i_mask),
    .i_new_irq(i_new_irq), .i_mret(i_mret), .o_ext_irq(o_ext_irq), .o_irq_id(o_irq_id),
    .o_pending(o_pending), .o_latency(o_latency), .o_latency_vld(o_latency_vld),
    .o_spurious(o_spurious)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic wait_ext(input int bound);
    for (int n = 0; n < bound && !o_ext_irq; n++) tick();
  endtask

  task automatic pulse_new();
    i_new_irq = 1'b1;
    tick();
    i_new_irq = 1'b0;
  endtask

  task automatic pulse_mret();
    i_mret = 1'b1;
    tick();
    i_mret = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_chk++; if (o_ext_irq !== 1'b0 || o_latency_vld !== 1'b0 || o_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got ext=%b vld=%b spur=%b exp 0", o_ext_irq, o_latency_vld, o_spurious); end
    n_chk++; if (o_irq_id !== 2'd0 || o_pending !== 4'd0 || o_latency !== 4'd0) begin n_fail++; $display("FAIL reset_values got id=%0d pend=%b lat=%0d exp 0", o_irq_id, o_pending, o_latency); end
    wb_rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_level();
    i_irq = 4'b0001;
    wait_ext(10);
    n_chk++; if (o_ext_irq !== 1'b1) begin n_fail++; $display("FAIL t1_ext_rise got %b exp 1", o_ext_irq); end
    n_chk++; if (o_irq_id !== 2'd0 || o_pending !== 4'b0001) begin n_fail++; $display("FAIL t1_grant got id=%0d pend=%b exp id=0 pend=0001", o_irq_id, o_pending); end
    repeat (4) tick();
    pulse_new();
    n_chk++; if (o_latency_vld !== 1'b1 || o_latency !== 4'd5) begin n_fail++; $display("FAIL t1_latency got vld=%b lat=%0d exp vld=1 lat=5", o_latency_vld, o_latency); end
    n_chk++; if (o_ext_irq !== 1'b0) begin n_fail++; $display("FAIL t1_service_ext got %b exp 0", o_ext_irq); end
    tick();
    n_chk++; if (o_latency_vld !== 1'b0) begin n_fail++; $display("FAIL t1_vld_one_cycle got %b exp 0", o_latency_vld); end
    pulse_mret();
    n_chk++; if (o_ext_irq !== 1'b0) begin n_fail++; $display("FAIL t1_gap_cycle got %b exp 0", o_ext_irq); end
    tick();
    n_chk++; if (o_ext_irq !== 1'b1) begin n_fail++; $display("FAIL t1_rerequest got %b exp 1", o_ext_irq); end
    i_irq = 4'b0000;
    repeat (5) tick();
    n_chk++; if (o_ext_irq !== 1'b0) begin n_fail++; $display("FAIL t1_drop got %b exp 0", o_ext_irq); end
  endtask

  task automatic test_edge();
    int k;
    k = $urandom_range(1, 6);
    i_irq = 4'b0100;
    tick();
    i_irq = 4'b0000;
    wait_ext(10);
    n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'd2 || o_pending !== 4'b0100) begin n_fail++; $display("FAIL t2_grant got ext=%b id=%0d pend=%b exp 1/2/0100", o_ext_irq, o_irq_id, o_pending); end
    repeat (k - 1) tick();
    pulse_new();
    n_chk++; if (o_latency !== 4'(k) || o_pending !== 4'b0000) begin n_fail++; $display("FAIL t2_take got lat=%0d pend=%b exp lat=%0d pend=0000", o_latency, o_pending, k); end
    pulse_mret();
    repeat (5) tick();
    n_chk++; if (o_ext_irq !== 1'b0) begin n_fail++; $display("FAIL t2_no_rerequest got %b exp 0", o_ext_irq); end
  endtask

  task automatic test_priority();
    int k1, k2, vlds;
    k1 = $urandom_range(1, 8);
    k2 = $urandom_range(1, 8);
    vlds = 0;
    i_irq = 4'b1010;
    wait_ext(10);
    n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'd1) begin n_fail++; $display("FAIL t3_first got ext=%b id=%0d exp 1/1", o_ext_irq, o_irq_id); end
    repeat (k1 - 1) tick();
    pulse_new();
    vlds += int'(o_latency_vld);
    n_chk++; if (o_latency !== 4'(k1)) begin n_fail++; $display("FAIL t3_lat1 got %0d exp %0d", o_latency, k1); end
    i_irq = 4'b1000;
    repeat (3) tick();
    pulse_mret();
    wait_ext(10);
    n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'd3) begin n_fail++; $display("FAIL t3_second got ext=%b id=%0d exp 1/3", o_ext_irq, o_irq_id); end
    repeat (k2 - 1) tick();
    pulse_new();
    vlds += int'(o_latency_vld);
    n_chk++; if (vlds != 2 || o_latency !== 4'(k2)) begin n_fail++; $display("FAIL t3_lat2 got strobes=%0d lat=%0d exp 2/%0d", vlds, o_latency, k2); end
    i_irq = 4'b0000;
    repeat (3) tick();
    pulse_mret();
    repeat (3) tick();
  endtask

  task automatic test_drop();
    int vlds;
    vlds = 0;
    i_irq = 4'b0010;
    wait_ext(10);
    n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'd1) begin n_fail++; $display("FAIL t4_grant got ext=%b id=%0d exp 1/1", o_ext_irq, o_irq_id); end
    i_irq = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      tick();
      vlds += int'(o_latency_vld);
    end
    n_chk++; if (o_ext_irq !== 1'b0 || vlds != 0) begin n_fail++; $display("FAIL t4_withdraw got ext=%b strobes=%0d exp 0/0", o_ext_irq, vlds); end
  endtask

  task automatic test_spurious();
    pulse_new();
    n_chk++; if (o_spurious !== 1'b1 || o_ext_irq !== 1'b0 || o_latency_vld !== 1'b0) begin n_fail++; $display("FAIL t5_new_idle got spur=%b ext=%b vld=%b exp 1/0/0", o_spurious, o_ext_irq, o_latency_vld); end
    tick();
    n_chk++; if (o_spurious !== 1'b0) begin n_fail++; $display("FAIL t5_spur_one_cycle got %b exp 0", o_spurious); end
    i_irq = 4'b0001;
    wait_ext(10);
    pulse_mret();
    n_chk++; if (o_spurious !== 1'b1 || o_ext_irq !== 1'b1) begin n_fail++; $display("FAIL t5_mret_req got spur=%b ext=%b exp 1/1", o_spurious, o_ext_irq); end
    i_new_irq = 1'b1;
    i_mret = 1'b1;
    tick();
    i_new_irq = 1'b0;
    i_mret = 1'b0;
    n_chk++; if (o_latency_vld !== 1'b1 || o_spurious !== 1'b1 || o_ext_irq !== 1'b0) begin n_fail++; $display("FAIL t5_both got vld=%b spur=%b ext=%b exp 1/1/0", o_latency_vld, o_spurious, o_ext_irq); end
    i_irq = 4'b0000;
    repeat (3) tick();
    pulse_mret();
    n_chk++; if (o_spurious !== 1'b0) begin n_fail++; $display("FAIL t5_legit_mret got spur=%b exp 0", o_spurious); end
    repeat (3) tick();
  endtask

  task automatic test_reset_service();
    i_irq = 4'b0010;
    wait_ext(10);
    repeat (2) tick();
    pulse_new();
    wb_rst_n = 1'b0;
    #1;
    n_chk++; if (o_ext_irq !== 1'b0 || o_irq_id !== 2'd0 || o_latency !== 4'd0 || o_latency_vld !== 1'b0 || o_spurious !== 1'b0 || o_pending !== 4'd0) begin n_fail++; $display("FAIL t6_async_reset got ext=%b id=%0d lat=%0d vld=%b spur=%b pend=%b exp all 0", o_ext_irq, o_irq_id, o_latency, o_latency_vld, o_spurious, o_pending); end
    i_irq = 4'b0100;
    tick();
    i_irq = 4'b0000;
    repeat (3) tick();
    wb_rst_n = 1'b1;
    repeat (6) tick();
    n_chk++; if (o_ext_irq !== 1'b0 || o_pending !== 4'd0) begin n_fail++; $display("FAIL t6_edge_in_reset got ext=%b pend=%b exp 0/0000", o_ext_irq, o_pending); end
  endtask

  task automatic test_saturation();
    i_irq = 4'b0001;
    wait_ext(10);
    repeat (19) tick();
    pulse_new();
    n_chk++; if (o_latency !== 4'd15 || o_latency_vld !== 1'b1) begin n_fail++; $display("FAIL t6_saturate got lat=%0d vld=%b exp 15/1", o_latency, o_latency_vld); end
    i_irq = 4'b0000;
    repeat (3) tick();
    pulse_mret();
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [3:0] lvl, msk, elig;
    bit ep2;
    int w, k, exp_lat;
    for (int it = 0; it < 24; it++) begin
      lvl = 4'($urandom) & 4'b1011;
      msk = 4'($urandom);
      ep2 = 1'($urandom);
      i_mask = 4'h0;
      tick();
      if (ep2) begin
        i_irq = 4'b0100;
        tick();
      end
      i_irq = lvl;
      repeat (4) tick();
      i_mask = msk;
      elig = (lvl | {1'b0, ep2, 2'b00}) & msk;
      w = -1;
      for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
      if (w < 0) begin
        repeat (6) tick();
        n_chk++; if (o_ext_irq !== 1'b0 || o_pending !== 4'd0) begin n_fail++; $display("FAIL rnd_idle it=%0d got ext=%b pend=%b exp 0/0000", it, o_ext_irq, o_pending); end
        i_irq = 4'b0000;
        repeat (4) tick();
        i_mask = 4'hF;
      end else begin
        k = $urandom_range(1, 20);
        exp_lat = k > LMAX ? LMAX : k;
        wait_ext(10);
        n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'(w) || o_pending !== elig) begin n_fail++; $display("FAIL rnd_grant it=%0d got ext=%b id=%0d pend=%b exp 1/%0d/%b", it, o_ext_irq, o_irq_id, o_pending, w, elig); end
        repeat (k - 1) tick();
        pulse_new();
        n_chk++; if (o_latency_vld !== 1'b1 || o_latency !== 4'(exp_lat)) begin n_fail++; $display("FAIL rnd_latency it=%0d got vld=%b lat=%0d exp 1/%0d", it, o_latency_vld, o_latency, exp_lat); end
        if (w == 2) ep2 = 1'b0;
        i_irq = 4'b0000;
        i_mask = 4'hF;
        repeat (3) tick();
        pulse_mret();
      end
      if (ep2) begin
        wait_ext(10);
        n_chk++; if (o_ext_irq !== 1'b1 || o_irq_id !== 2'd2) begin n_fail++; $display("FAIL rnd_edge_drain it=%0d got ext=%b id=%0d exp 1/2", it, o_ext_irq, o_irq_id); end
        pulse_new();
        pulse_mret();
      end
      repeat (4) tick();
      n_chk++; if (o_ext_irq !== 1'b0 || o_pending !== 4'd0) begin n_fail++; $display("FAIL rnd_quiet it=%0d got ext=%b pend=%b exp 0/0000", it, o_ext_irq, o_pending); end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_drop();
    test_spurious();
    test_reset_service();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
